// File: rtl/fc_layer_pkg.sv
// fc_layer_pkg: shared types, default sizes and requantisation helper
// for the streaming fully connected layer engines.
package fc_layer_pkg;

  localparam int FC_DIM_INPUT  = 96;
  localparam int FC_DIM_OUTPUT = 8;
  localparam int FC_INPUT_W    = 16;
  localparam int FC_OUTPUT_W   = 8;
  localparam int FC_WEIGHT_W   = 8;
  localparam int FC_ACC_W      = 32;
  localparam int FC_OUT_SHIFT  = 8;
  localparam int FC_BIAS_SHIFT = 8;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_QUANT = 2'd2
  } fc_state_e;

  // rows = weight rows plus one bias row
  function automatic int fc_row_aw(input int dim_input);
    return $clog2(dim_input + 1);
  endfunction

  // round half up by 2^shift, then clamp to a signed out_w range
  function automatic logic signed [63:0] fc_round_sat(
    input logic signed [63:0] acc,
    input int                 shift,
    input int                 out_w
  );
    logic signed [63:0] t;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    t  = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    if (t > hi) begin
      t = hi;
    end else if (t < lo) begin
      t = lo;
    end
    return t;
  endfunction

endpackage

// File: rtl/fc_weight_ram.sv
// fc_weight_ram: simple dual-port synchronous RAM for weight/bias rows.
// Contents are never reset.
module fc_weight_ram #(
  parameter int DEPTH = 97,
  parameter int WIDTH = 64,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // registered read port
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fc_layer_stream.sv
// fc_layer_stream: serial-in, parallel-out fully connected layer.
// Define FC_LAYER_RELU_EN to clamp negative outputs to zero.
module fc_layer_stream
  import fc_layer_pkg::*;
#(
  parameter int DIM_INPUT  = FC_DIM_INPUT,
  parameter int DIM_OUTPUT = FC_DIM_OUTPUT,
  parameter int INPUT_W    = FC_INPUT_W,
  parameter int OUTPUT_W   = FC_OUTPUT_W,
  parameter int WEIGHT_W   = FC_WEIGHT_W,
  parameter int ACC_W      = FC_ACC_W,
  parameter int OUT_SHIFT  = FC_OUT_SHIFT,
  parameter int BIAS_SHIFT = FC_BIAS_SHIFT,
  localparam int AW        = fc_row_aw(DIM_INPUT),
  localparam int ROW_W     = DIM_OUTPUT * WEIGHT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_vld,
  input  logic [INPUT_W-1:0]  in_dat,
  output logic                out_vld,
  output logic [OUTPUT_W-1:0] out_dat [DIM_OUTPUT],
  input  logic                wt_we,
  input  logic [AW-1:0]       wt_addr,
  input  logic [ROW_W-1:0]    wt_wdata,
  output logic                busy,
  output logic                in_drop,
  output logic                wt_err
);

  localparam int PROD_W = INPUT_W + WEIGHT_W;

  fc_state_e          state_q, state_d;
  logic [AW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               out_vld_q, out_vld_d;
  logic               in_drop_q, in_drop_d;
  logic               wt_err_q, wt_err_d;
  logic [INPUT_W-1:0] in_r_q, in_r_d;
  logic               s1_vld_q, s1_vld_d;
  logic               s1_first_q, s1_first_d;
  logic [ROW_W-1:0]   bias_q, bias_d;
  logic [ROW_W-1:0]   rd_row;

  logic accept;
  logic last;
  logic wt_ok;
  logic bias_we;

  assign accept  = in_vld && (state_q == ST_ACC);
  assign last    = (cnt_q == AW'(DIM_INPUT - 1));
  assign wt_ok   = wt_we && !busy_q &&
                   (wt_addr <= AW'(DIM_INPUT));
  assign bias_we = wt_ok && (wt_addr == AW'(DIM_INPUT));

  fc_weight_ram #(
    .DEPTH (DIM_INPUT + 1),
    .WIDTH (ROW_W),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wt_ok),
    .waddr (wt_addr),
    .wdata (wt_wdata),
    .re    (accept),
    .raddr (cnt_q),
    .rdata (rd_row)
  );

  // next state, beat counter, flags and stage-0 capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    out_vld_d  = 1'b0;
    in_r_d     = in_r_q;
    s1_vld_d   = accept;
    s1_first_d = accept && (cnt_q == '0);
    in_drop_d  = in_drop_q | (in_vld && (state_q != ST_ACC));
    wt_err_d   = wt_err_q | (wt_we && !wt_ok);
    if (accept) begin
      in_r_d = in_dat;
    end
    unique case (state_q)
      ST_ACC: begin
        if (accept) begin
          busy_d = 1'b1;
          if (last) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_QUANT;
      end
      ST_QUANT: begin
        state_d   = ST_ACC;
        busy_d    = 1'b0;
        out_vld_d = 1'b1;
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  // control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ACC;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      out_vld_q  <= 1'b0;
      in_drop_q  <= 1'b0;
      wt_err_q   <= 1'b0;
      in_r_q     <= '0;
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      out_vld_q  <= out_vld_d;
      in_drop_q  <= in_drop_d;
      wt_err_q   <= wt_err_d;
      in_r_q     <= in_r_d;
      s1_vld_q   <= s1_vld_d;
      s1_first_q <= s1_first_d;
    end
  end

  // bias copy lets row 0 and the bias be used in the same cycle
  always_comb begin
    bias_d = bias_q;
    if (bias_we) begin
      bias_d = wt_wdata;
    end
  end

  // bias copy is part of weight storage and survives reset
  always_ff @(posedge clk) begin
    bias_q <= bias_d;
  end

  for (genvar gi = 0; gi < DIM_OUTPUT; gi++) begin : g_mac
    logic [WEIGHT_W-1:0] w;
    logic [WEIGHT_W-1:0] b;
    logic [PROD_W-1:0]   xs;
    logic [PROD_W-1:0]   ws;
    logic [PROD_W-1:0]   prod;
    logic [ACC_W-1:0]    base;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [OUTPUT_W-1:0] q_q, q_d;

    // stage-1 MAC and requantisation for one neuron
    always_comb begin
      w    = rd_row[gi*WEIGHT_W +: WEIGHT_W];
      b    = bias_q[gi*WEIGHT_W +: WEIGHT_W];
      xs   = {{WEIGHT_W{in_r_q[INPUT_W-1]}}, in_r_q};
      ws   = {{INPUT_W{w[WEIGHT_W-1]}}, w};
      prod = PROD_W'($signed(xs) * $signed(ws));
      base = acc_q;
      if (s1_first_q) begin
        base = {{(ACC_W-WEIGHT_W){b[WEIGHT_W-1]}}, b}
               << BIAS_SHIFT;
      end
      acc_d = acc_q;
      if (s1_vld_q) begin
        acc_d = base +
                {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
      end
      q_d = q_q;
      if (state_q == ST_QUANT) begin
        q_d = OUTPUT_W'(fc_round_sat(
                {{(64-ACC_W){acc_q[ACC_W-1]}}, acc_q},
                OUT_SHIFT, OUTPUT_W));
`ifdef FC_LAYER_RELU_EN
        if (q_d[OUTPUT_W-1]) begin
          q_d = '0;
        end
`else
        q_d = q_d;
`endif
      end
    end

    // accumulator and output holding register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
        q_q   <= '0;
      end else begin
        acc_q <= acc_d;
        q_q   <= q_d;
      end
    end

    assign out_dat[gi] = q_q;
  end

  assign out_vld = out_vld_q;
  assign busy    = busy_q;
  assign in_drop = in_drop_q;
  assign wt_err  = wt_err_q;

endmodule

// File: tb/tb_fc_layer_stream.sv
// tb_fc_layer_stream: directed and randomized checks of fc_layer_stream
// against an arithmetic reference model.
module tb_fc_layer_stream;

  localparam int NI = 96;
  localparam int NO = 8;

  logic       clk;
  logic       rst_n;
  logic       in_vld;
  logic [15:0] in_dat;
  logic       out_vld;
  logic [7:0] out_dat [NO];
  logic       wt_we;
  logic [6:0] wt_addr;
  logic [63:0] wt_wdata;
  logic       busy;
  logic       in_drop;
  logic       wt_err;

  int checks   = 0;
  int failures = 0;

  int wm [NI+1][NO];
  int xv [NI];
  int expv [NO];

  fc_layer_stream dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (in_vld),
    .in_dat   (in_dat),
    .out_vld  (out_vld),
    .out_dat  (out_dat),
    .wt_we    (wt_we),
    .wt_addr  (wt_addr),
    .wt_wdata (wt_wdata),
    .busy     (busy),
    .in_drop  (in_drop),
    .wt_err   (wt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // y = sat(round((bias*256 + sum x*w) / 256))
  function automatic void model();
    longint acc;
    longint r;
    for (int o = 0; o < NO; o++) begin
      acc = longint'(wm[NI][o]) * 256;
      for (int k = 0; k < NI; k++)
        acc += longint'(xv[k]) * longint'(wm[k][o]);
      r = (acc + 128) >>> 8;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
`ifdef FC_LAYER_RELU_EN
      if (r < 0) r = 0;
`endif
      expv[o] = int'(r);
    end
  endfunction

  task automatic wt_write(input int addr, input int row [NO],
                          input bit ok);
    wt_we   = 1'b1;
    wt_addr = 7'(addr);
    for (int i = 0; i < NO; i++)
      wt_wdata[i*8 +: 8] = 8'(row[i]);
    step();
    wt_we = 1'b0;
    if (ok)
      for (int i = 0; i < NO; i++) wm[addr][i] = row[i];
  endtask

  task automatic fill(input int wv, input int bv);
    int row [NO];
    for (int i = 0; i < NO; i++) row[i] = wv;
    for (int r = 0; r < NI; r++) wt_write(r, row, 1'b1);
    for (int i = 0; i < NO; i++) row[i] = bv;
    wt_write(NI, row, 1'b1);
  endtask

  task automatic fill_rand();
    int row [NO];
    for (int r = 0; r <= NI; r++) begin
      for (int i = 0; i < NO; i++)
        row[i] = int'($urandom_range(255, 0)) - 128;
      wt_write(r, row, 1'b1);
    end
  endtask

  task automatic feed(input int from, input int to,
                      input int maxgap);
    int gap;
    for (int k = from; k <= to; k++) begin
      gap = int'($urandom_range(maxgap, 0));
      in_vld = 1'b0;
      repeat (gap) step();
      in_vld = 1'b1;
      in_dat = 16'(xv[k]);
      step();
    end
    in_vld = 1'b0;
  endtask

  task automatic finish(input string tag, input bit inject,
                        input bit exp_drop);
    int cyc;
    if (inject) begin
      in_vld = 1'b1;
      in_dat = 16'($urandom);
    end
    chk({tag, "_busy_hi"}, 64'(busy), 64'(1));
    cyc = 1;
    while (out_vld !== 1'b1 && cyc < 8) begin
      step();
      in_vld = 1'b0;
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(3));
    chk({tag, "_busy_lo"}, 64'(busy), 64'(0));
    model();
    for (int o = 0; o < NO; o++)
      chk($sformatf("%s_out%0d", tag, o),
          $signed(out_dat[o]), 64'(expv[o]));
    step();
    chk({tag, "_pulse"}, 64'(out_vld), 64'(0));
    chk({tag, "_hold"}, $signed(out_dat[NO-1]),
        64'(expv[NO-1]));
    chk({tag, "_drop"}, 64'(in_drop), 64'(exp_drop));
  endtask

  task automatic set_x(input int v);
    for (int k = 0; k < NI; k++) xv[k] = v;
  endtask

  task automatic rand_x();
    for (int k = 0; k < NI; k++)
      xv[k] = int'($urandom_range(127, 0)) - 64;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int row [NO];
    rst_n    = 1'b0;
    in_vld   = 1'b0;
    in_dat   = '0;
    wt_we    = 1'b0;
    wt_addr  = '0;
    wt_wdata = '0;
    step();
    step();
    chk("rst_out_vld", 64'(out_vld), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_in_drop", 64'(in_drop), 64'(0));
    chk("rst_wt_err", 64'(wt_err), 64'(0));
    for (int o = 0; o < NO; o++)
      chk($sformatf("rst_out%0d", o), 64'(out_dat[o]), 64'(0));
    rst_n = 1'b1;
    step();

    fill(1, 0);
    set_x(256);
    feed(0, NI - 1, 0);
    finish("ident", 1'b0, 1'b0);
    chk("ident_const", $signed(out_dat[3]), 64'(96));

    fill(127, 0);
    set_x(32767);
    feed(0, NI - 1, 0);
    finish("satp", 1'b0, 1'b0);
    chk("satp_const", $signed(out_dat[0]), 64'(127));

    fill(-128, 0);
    feed(0, NI - 1, 0);
    finish("satn", 1'b0, 1'b0);

    fill(0, 1);
    for (int i = 0; i < NO; i++) row[i] = 1;
    wt_write(0, row, 1'b1);
    set_x(0);
    xv[0] = 128;
    feed(0, NI - 1, 0);
    finish("rnd_pos", 1'b0, 1'b0);
    chk("rnd_pos_const", $signed(out_dat[5]), 64'(2));

    fill(0, -1);
    wt_write(0, row, 1'b1);
    set_x(0);
    xv[0] = -128;
    feed(0, NI - 1, 0);
    finish("rnd_neg", 1'b0, 1'b0);

    fill(1, 0);
    set_x(256);
    feed(0, NI - 1, 5);
    finish("gap", 1'b1, 1'b1);
    feed(0, NI - 1, 0);
    finish("after_drop", 1'b0, 1'b1);

    fill_rand();
    for (int v = 0; v < 3; v++) begin
      rand_x();
      feed(0, NI - 1, 2);
      finish($sformatf("rand%0d", v), 1'b0, 1'b1);
    end

    rand_x();
    feed(0, 39, 1);
    do_reset();
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_drop", 64'(in_drop), 64'(0));
    rand_x();
    feed(0, NI - 1, 1);
    finish("post_rst", 1'b0, 1'b0);

    chk("werr_init", 64'(wt_err), 64'(0));
    for (int i = 0; i < NO; i++) row[i] = 77;
    wt_write(97, row, 1'b0);
    chk("werr_addr", 64'(wt_err), 64'(1));
    rand_x();
    feed(0, NI - 1, 0);
    finish("werr_addr_vec", 1'b0, 1'b0);

    do_reset();
    chk("werr_clr", 64'(wt_err), 64'(0));
    rand_x();
    feed(0, 9, 0);
    for (int i = 0; i < NO; i++) row[i] = -100;
    wt_write(5, row, 1'b0);
    chk("werr_busy", 64'(wt_err), 64'(1));
    feed(10, NI - 1, 0);
    finish("werr_busy_vec", 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
